// File: rtl/control_pipe_hz.sv
// control_pipe_hz: decodes the ID-stage opcode into the control bundle, carries it
// through the ID/EX, EX/MEM and MEM/WB registers, stalls on load-use and
// branch-operand hazards, resolves jumps and beq/bne in ID, and honours a global freeze.
module control_pipe_hz #(
  parameter int unsigned REG_AW    = 5,
  parameter bit          BR_HAZ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opCode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              zero,
  input  logic              freeze,
  output logic              jump,
  output logic              branchEq,
  output logic              branchNeq,
  output logic              branch_taken,
  output logic              ifflush,
  output logic              stall,
  output logic              ex_regDst,
  output logic              ex_aluSrc,
  output logic [1:0]        ex_aluOp,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_memtoReg,
  output logic              ex_regWrite,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              mem_memtoReg,
  output logic              mem_regWrite,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_memtoReg,
  output logic              wb_regWrite,
  output logic [REG_AW-1:0] wb_wreg,
  output logic              ill_op
);

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regWrite;
    logic       ill;
  } idex_t;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic memtoReg;
    logic regWrite;
  } exmem_t;

  idex_t             dec;
  idex_t             idex_d, idex_q;
  logic [REG_AW-1:0] ex_wreg_d, ex_wreg_q;
  exmem_t            exmem_q;
  logic [REG_AW-1:0] mem_wreg_q;
  logic              wb_memtoReg_q, wb_regWrite_q;
  logic [REG_AW-1:0] wb_wreg_q;
  logic              ill_op_q;

  logic ex_hit, mem_hit, lu, bh, hz;

  // Opcode decode into the ID control bundle plus the raw jump/branch strobes.
  always_comb begin
    dec       = '0;
    jump      = 1'b0;
    branchEq  = 1'b0;
    branchNeq = 1'b0;
    case (opCode)
      6'b000000: begin dec.regDst = 1'b1; dec.regWrite = 1'b1; dec.aluOp = 2'b10; end
      6'b000010: jump = 1'b1;
      6'b000100: begin branchEq  = 1'b1; dec.aluOp = 2'b01; end
      6'b000101: begin branchNeq = 1'b1; dec.aluOp = 2'b01; end
      6'b001000: begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      6'b001100: begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.aluOp = 2'b11; end
      6'b100011: begin
        dec.memRead  = 1'b1;
        dec.memtoReg = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
      end
      6'b101011: begin dec.memWrite = 1'b1; dec.aluSrc = 1'b1; end
      default:   dec.ill = 1'b1;
    endcase
  end

  // Register 0 is never a real dependency, so it is excluded from matching.
  assign ex_hit  = (ex_wreg_q  != '0) && ((ex_wreg_q  == id_rs) || (ex_wreg_q  == id_rt));
  assign mem_hit = (mem_wreg_q != '0) && ((mem_wreg_q == id_rs) || (mem_wreg_q == id_rt));

  assign lu = idex_q.memRead & ex_hit;
  assign bh = BR_HAZ_EN & (branchEq | branchNeq) &
              ((idex_q.regWrite & ex_hit) | (exmem_q.memRead & mem_hit));
  assign hz = lu | bh;

  assign stall        = freeze | hz;
  assign branch_taken = ~stall & ((branchEq & zero) | (branchNeq & ~zero));
  assign ifflush      = ~stall & (jump | branch_taken);

  // ID/EX next value: a bubble on a hazard, otherwise the decoded bundle.
  always_comb begin
    idex_d    = '0;
    ex_wreg_d = '0;
    if (!hz) begin
      idex_d    = dec;
      ex_wreg_d = dec.regDst ? id_rd : id_rt;
    end
  end

  // Pipeline registers; freeze holds every stage and suppresses the illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q        <= '0;
      ex_wreg_q     <= '0;
      exmem_q       <= '0;
      mem_wreg_q    <= '0;
      wb_memtoReg_q <= 1'b0;
      wb_regWrite_q <= 1'b0;
      wb_wreg_q     <= '0;
      ill_op_q      <= 1'b0;
    end else if (freeze) begin
      ill_op_q <= 1'b0;
    end else begin
      idex_q        <= idex_d;
      ex_wreg_q     <= ex_wreg_d;
      exmem_q       <= '{memRead:  idex_q.memRead,  memWrite: idex_q.memWrite,
                         memtoReg: idex_q.memtoReg, regWrite: idex_q.regWrite};
      mem_wreg_q    <= ex_wreg_q;
      wb_memtoReg_q <= exmem_q.memtoReg;
      wb_regWrite_q <= exmem_q.regWrite;
      wb_wreg_q     <= mem_wreg_q;
      ill_op_q      <= idex_d.ill;
    end
  end

  assign ex_regDst    = idex_q.regDst;
  assign ex_aluSrc    = idex_q.aluSrc;
  assign ex_aluOp     = idex_q.aluOp;
  assign ex_memRead   = idex_q.memRead;
  assign ex_memWrite  = idex_q.memWrite;
  assign ex_memtoReg  = idex_q.memtoReg;
  assign ex_regWrite  = idex_q.regWrite;
  assign ex_wreg      = ex_wreg_q;
  assign mem_memRead  = exmem_q.memRead;
  assign mem_memWrite = exmem_q.memWrite;
  assign mem_memtoReg = exmem_q.memtoReg;
  assign mem_regWrite = exmem_q.regWrite;
  assign mem_wreg     = mem_wreg_q;
  assign wb_memtoReg  = wb_memtoReg_q;
  assign wb_regWrite  = wb_regWrite_q;
  assign wb_wreg      = wb_wreg_q;
  assign ill_op       = ill_op_q;

endmodule

// File: tb/tb_control_pipe_hz.sv
// tb_control_pipe_hz: two instances (branch hazards enabled / disabled) driven with
// directed and random instruction streams, checked against a stage-record model.
module tb_control_pipe_hz;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opCode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       zero, freeze;

  logic       jump_o [2], beq_o [2], bne_o [2], bt_o [2], fl_o [2], st_o [2];
  logic       exRd_o [2], exAs_o [2], exMr_o [2], exMw_o [2], exMt_o [2], exRw_o [2];
  logic [1:0] exOp_o [2];
  logic [4:0] exW_o  [2], memW_o [2], wbW_o [2];
  logic       mMr_o  [2], mMw_o [2], mMt_o [2], mRw_o [2];
  logic       wMt_o  [2], wRw_o [2], ill_o [2];

  int unsigned errs = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_pipe_hz #(.REG_AW(5), .BR_HAZ_EN(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .zero(zero), .freeze(freeze),
      .jump(jump_o[g]), .branchEq(beq_o[g]), .branchNeq(bne_o[g]),
      .branch_taken(bt_o[g]), .ifflush(fl_o[g]), .stall(st_o[g]),
      .ex_regDst(exRd_o[g]), .ex_aluSrc(exAs_o[g]), .ex_aluOp(exOp_o[g]),
      .ex_memRead(exMr_o[g]), .ex_memWrite(exMw_o[g]), .ex_memtoReg(exMt_o[g]),
      .ex_regWrite(exRw_o[g]), .ex_wreg(exW_o[g]),
      .mem_memRead(mMr_o[g]), .mem_memWrite(mMw_o[g]), .mem_memtoReg(mMt_o[g]),
      .mem_regWrite(mRw_o[g]), .mem_wreg(memW_o[g]),
      .wb_memtoReg(wMt_o[g]), .wb_regWrite(wRw_o[g]), .wb_wreg(wbW_o[g]),
      .ill_op(ill_o[g])
    );
  end

  // One instruction as it travels down the pipe.
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regWrite;
    logic       ill;
    logic [4:0] wreg;
  } rec_t;

  rec_t m_ex [2], m_mem [2], m_wb [2];
  logic m_ill [2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Control table {regDst,jump,beq,bne,memRead,memtoReg,memWrite,aluSrc,regWrite,aluOp}.
  function automatic logic [10:0] ctl_of(input logic [5:0] op);
    case (op)
      6'b000000: return 11'b1_0_0_0_0_0_0_0_1_10;
      6'b000010: return 11'b0_1_0_0_0_0_0_0_0_00;
      6'b000100: return 11'b0_0_1_0_0_0_0_0_0_01;
      6'b000101: return 11'b0_0_0_1_0_0_0_0_0_01;
      6'b001000: return 11'b0_0_0_0_0_0_0_1_1_00;
      6'b001100: return 11'b0_0_0_0_0_0_0_1_1_11;
      6'b100011: return 11'b0_0_0_0_1_1_0_1_1_00;
      6'b101011: return 11'b0_0_0_0_0_0_1_1_0_00;
      default:   return 11'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h23, 6'h2b};
  endfunction

  function automatic bit hit(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_ill[k] = 1'b0;
    end
  endtask

  task automatic check_regs(input string pfx);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s k%0d ex", pfx, k),
            {exRd_o[k], exAs_o[k], exOp_o[k], exMr_o[k], exMw_o[k], exMt_o[k], exRw_o[k], exW_o[k]},
            {m_ex[k].regDst, m_ex[k].aluSrc, m_ex[k].aluOp, m_ex[k].memRead, m_ex[k].memWrite,
             m_ex[k].memtoReg, m_ex[k].regWrite, m_ex[k].wreg});
      check($sformatf("%s k%0d mem", pfx, k),
            {mMr_o[k], mMw_o[k], mMt_o[k], mRw_o[k], memW_o[k]},
            {m_mem[k].memRead, m_mem[k].memWrite, m_mem[k].memtoReg, m_mem[k].regWrite, m_mem[k].wreg});
      check($sformatf("%s k%0d wb", pfx, k),
            {wMt_o[k], wRw_o[k], wbW_o[k]},
            {m_wb[k].memtoReg, m_wb[k].regWrite, m_wb[k].wreg});
      check($sformatf("%s k%0d ill_op", pfx, k), ill_o[k], m_ill[k]);
    end
  endtask

  // Present one ID instruction for one cycle; called just after a falling edge.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic z, input logic frz);
    logic [10:0] c;
    bit   lu, bh, st, bt;
    rec_t nr;
    rec_t n_ex [2], n_mem [2], n_wb [2];
    logic n_ill [2];
    opCode = op; id_rs = rs; id_rt = rt; id_rd = rd; zero = z; freeze = frz;
    #1;
    c  = ctl_of(op);
    nr = '{regDst: c[10], aluSrc: c[3], aluOp: c[1:0], memRead: c[6], memWrite: c[4],
           memtoReg: c[5], regWrite: c[2], ill: !is_legal(op), wreg: (c[10] ? rd : rt)};
    for (int k = 0; k < 2; k++) begin
      lu = m_ex[k].memRead && hit(m_ex[k].wreg, rs, rt);
      bh = (k == 0) && (c[8] || c[7]) &&
           ((m_ex[k].regWrite && hit(m_ex[k].wreg, rs, rt)) ||
            (m_mem[k].memRead && hit(m_mem[k].wreg, rs, rt)));
      st = frz || lu || bh;
      bt = !st && ((c[8] && z) || (c[7] && !z));
      check($sformatf("k%0d jump", k), jump_o[k], c[9]);
      check($sformatf("k%0d beq", k), beq_o[k], c[8]);
      check($sformatf("k%0d bne", k), bne_o[k], c[7]);
      check($sformatf("k%0d stall", k), st_o[k], st);
      check($sformatf("k%0d taken", k), bt_o[k], bt);
      check($sformatf("k%0d ifflush", k), fl_o[k], !st && (c[9] || bt));
      if (frz) begin
        n_ex[k] = m_ex[k]; n_mem[k] = m_mem[k]; n_wb[k] = m_wb[k]; n_ill[k] = 1'b0;
      end else begin
        n_wb[k]  = m_mem[k];
        n_mem[k] = m_ex[k];
        n_ex[k]  = (lu || bh) ? rec_t'('0) : nr;
        n_ill[k] = n_ex[k].ill;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = n_ex[k]; m_mem[k] = n_mem[k]; m_wb[k] = n_wb[k]; m_ill[k] = n_ill[k];
    end
    check_regs("reg");
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle: registers must clear with no clock edge.
  task automatic mid_reset(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    opCode = op; id_rs = rs; id_rt = rt; id_rd = 5'd0; zero = 1'b0; freeze = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_regs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] legal_ops [8];
    logic [5:0] bad_ops   [4];
    logic [5:0] op;
    legal_ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h23, 6'h2b};
    bad_ops   = '{6'h3f, 6'h01, 6'h0d, 6'h10};
    rst_n = 1'b0; opCode = 6'h3f; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    zero = 1'b0; freeze = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    check_regs("reset");
    rst_n = 1'b1;

    // load-use: lw $2 then add using $2
    step(6'h23, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(6'h00, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0);
    step(6'h00, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0);
    // beq/bne without hazard, taken and not taken
    step(6'h04, 5'd1, 5'd3, 5'd0, 1'b1, 1'b0);
    step(6'h04, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0);
    step(6'h05, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0);
    step(6'h05, 5'd1, 5'd3, 5'd0, 1'b1, 1'b0);
    // addi $5 then beq on $5
    step(6'h08, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
    step(6'h04, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
    step(6'h04, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
    // lw $4 then beq on $4: two stalls with hazards enabled
    step(6'h23, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0);
    step(6'h04, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0);
    step(6'h04, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0);
    step(6'h04, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0);
    // lw to $0 never hazards
    step(6'h23, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(6'h04, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    // freeze with sw in ID/EX
    step(6'h2b, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    repeat (3) step(6'h02, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    // illegal opcode, including a freeze while it is being presented
    step(6'h3f, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(6'h3f, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    step(6'h3f, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    // jump during load-use: stall first, flush once released
    step(6'h23, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0);
    step(6'h02, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
    step(6'h02, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
    // reset in the middle of a load-use stall
    step(6'h23, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    mid_reset(6'h00, 5'd7, 5'd1);
    step(6'h00, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);

    // random instruction stream over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
      else                           op = bad_ops[$urandom_range(0, 3)];
      if ($urandom_range(0, 199) == 0) mid_reset(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      else step(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
